// File: rtl/io_command_queue_if.sv
// Handshake bundle between the IO command queue, the core issue stage,
// the IO controller and the register-file writeback port.
interface io_command_queue_if #(
   parameter int DATA_WIDTH = 16
);
   // core issue side
   logic                  Cmd_Valid;
   logic                  Cmd_Ready;
   logic                  Cmd_CommandEn;
   logic                  Cmd_ResponseRequested;
   logic [3:0]            Cmd_DestReg;
   logic [DATA_WIDTH-1:0] Cmd_Data;

   // IO controller side
   logic                  IO_REQ;
   logic                  IO_ACK;
   logic                  IO_CommandEn;
   logic                  IO_ResponseRequested;
   logic [3:0]            IO_DestRegOut;
   logic [DATA_WIDTH-1:0] IO_DataOut;
   logic                  IO_RegResponseFlag;
   logic                  IO_MemResponseFlag;
   logic [3:0]            IO_DestRegIn;
   logic [DATA_WIDTH-1:0] IO_DataIn;

   // register-file writeback side
   logic                  WB_Valid;
   logic                  WB_Ready;
   logic [3:0]            WB_DestReg;
   logic [DATA_WIDTH-1:0] WB_Data;

   // the queue's view
   modport slave (
      input  Cmd_Valid, Cmd_CommandEn, Cmd_ResponseRequested, Cmd_DestReg, Cmd_Data,
      output Cmd_Ready,
      output IO_REQ, IO_CommandEn, IO_ResponseRequested, IO_DestRegOut, IO_DataOut,
      input  IO_ACK, IO_RegResponseFlag, IO_MemResponseFlag, IO_DestRegIn, IO_DataIn,
      output WB_Valid, WB_DestReg, WB_Data,
      input  WB_Ready
   );

   // the surrounding core/controller view
   modport master (
      output Cmd_Valid, Cmd_CommandEn, Cmd_ResponseRequested, Cmd_DestReg, Cmd_Data,
      input  Cmd_Ready,
      input  IO_REQ, IO_CommandEn, IO_ResponseRequested, IO_DestRegOut, IO_DataOut,
      output IO_ACK, IO_RegResponseFlag, IO_MemResponseFlag, IO_DestRegIn, IO_DataIn,
      input  WB_Valid, WB_DestReg, WB_Data,
      output WB_Ready
   );
endinterface

// File: rtl/io_command_queue.sv
// IO command queue: buffers core IO commands for a combinational GPIO controller
// and holds the controller's register response in a one-entry writeback slot.
module io_command_queue #(
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     async_rst_n,
   input  logic                     clk_en,
   io_command_queue_if.slave        bus,
   output logic [$clog2(DEPTH):0]   Occupancy,
   output logic                     MemResp_Err
);

   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      logic                  commandEn;
      logic                  responseRequested;
      logic [3:0]            destReg;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   typedef enum logic {
      SLOT_EMPTY,
      SLOT_FULL
   } slot_state_t;

   entry_t      mem [DEPTH];
   entry_t      head;
   logic [PW:0] rdPtr;
   logic [PW:0] wrPtr;
   logic        empty;
   logic        full;
   logic        slotFree;
   logic        ioReq;
   logic        pop;
   logic        cmdReady;
   logic        push;
   logic        capture;
   logic        drain;
   logic        wbValid;

   slot_state_t           slotState;
   slot_state_t           slotNext;
   logic [3:0]            wbDestReg;
   logic [DATA_WIDTH-1:0] wbData;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign empty = (rdPtr == wrPtr);
   assign full  = (rdPtr[PW] != wrPtr[PW]) && (rdPtr[PW-1:0] == wrPtr[PW-1:0]);
   assign head  = mem[rdPtr[PW-1:0]];

   assign slotFree = !wbValid || bus.WB_Ready;
   assign ioReq    = !empty && clk_en && (!head.responseRequested || slotFree);
   assign pop      = ioReq && bus.IO_ACK;
   assign cmdReady = clk_en && (!full || pop);
   assign push     = bus.Cmd_Valid && cmdReady;
   assign capture  = pop && bus.IO_RegResponseFlag;
   assign drain    = wbValid && bus.WB_Ready && clk_en;

   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         rdPtr <= '0;
         wrPtr <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wrPtr[PW-1:0]] <= '{
            commandEn:         bus.Cmd_CommandEn,
            responseRequested: bus.Cmd_ResponseRequested,
            destReg:           bus.Cmd_DestReg,
            data:              bus.Cmd_Data
         };
      end
   end

   // Writeback slot: state register
   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) slotState <= SLOT_EMPTY;
      else              slotState <= slotNext;
   end

   // Writeback slot: next state; a capture in a drain cycle reloads the slot
   always_comb begin
      slotNext = slotState;
      if (capture)    slotNext = SLOT_FULL;
      else if (drain) slotNext = SLOT_EMPTY;
   end

   // Writeback slot: outputs
   always_comb begin
      wbValid = (slotState == SLOT_FULL);
   end

   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         wbDestReg <= '0;
         wbData    <= '0;
      end else if (capture) begin
         wbDestReg <= bus.IO_DestRegIn;
         wbData    <= bus.IO_DataIn;
      end
   end

   // Memory responses are not supported; flag them and let the pop complete.
   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n)                         MemResp_Err <= 1'b0;
      else if (pop && bus.IO_MemResponseFlag)   MemResp_Err <= 1'b1;
   end

   assign Occupancy = wrPtr - rdPtr;

   assign bus.Cmd_Ready            = cmdReady;
   assign bus.IO_REQ               = ioReq;
   assign bus.IO_CommandEn         = head.commandEn;
   assign bus.IO_ResponseRequested = head.responseRequested;
   assign bus.IO_DestRegOut        = head.destReg;
   assign bus.IO_DataOut           = head.data;
   assign bus.WB_Valid             = wbValid;
   assign bus.WB_DestReg           = wbDestReg;
   assign bus.WB_Data              = wbData;

endmodule

// File: tb/tb_io_command_queue.sv
// Bench for io_command_queue: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_io_command_queue;
   localparam int DEPTH = 4;
   localparam int DW    = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clk_en = 1'b1;
   logic [2:0]    occupancy;
   logic          memRespErr;

   io_command_queue_if #(.DATA_WIDTH(DW)) bus();

   io_command_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
      .clk        (clk),
      .async_rst_n(rst_n),
      .clk_en     (clk_en),
      .bus        (bus),
      .Occupancy  (occupancy),
      .MemResp_Err(memRespErr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic        ce;
      logic        rr;
      logic [3:0]  dest;
      logic [15:0] data;
   } cmd_t;

   cmd_t        mq[$];
   logic [15:0] delivered[$];
   logic        mValid = 1'b0;
   logic [3:0]  mDest  = '0;
   logic [15:0] mData  = '0;
   logic        mErr   = 1'b0;
   logic        expReq, expPop, expReady, expPush;
   cmd_t        popped;

   always @(negedge clk) begin
      if (!rst_n) begin
         mq.delete();
         mValid = 1'b0; mDest = '0; mData = '0; mErr = 1'b0;
         chk("rst_IO_REQ", bus.IO_REQ, 0);
         chk("rst_WB_Valid", bus.WB_Valid, 0);
         chk("rst_Occupancy", occupancy, 0);
         chk("rst_MemResp_Err", memRespErr, 0);
      end else begin
         expReq   = clk_en && (mq.size() > 0) && (!mq[0].rr || !mValid || bus.WB_Ready);
         expPop   = expReq && bus.IO_ACK;
         expReady = clk_en && ((mq.size() < DEPTH) || expPop);
         expPush  = bus.Cmd_Valid && expReady;

         chk("IO_REQ", bus.IO_REQ, expReq);
         chk("Cmd_Ready", bus.Cmd_Ready, expReady);
         chk("Occupancy", occupancy, mq.size());
         chk("WB_Valid", bus.WB_Valid, mValid);
         chk("WB_DestReg", bus.WB_DestReg, mDest);
         chk("WB_Data", bus.WB_Data, mData);
         chk("MemResp_Err", memRespErr, mErr);
         if (mq.size() > 0)
            chk("head", {bus.IO_CommandEn, bus.IO_ResponseRequested, bus.IO_DestRegOut, bus.IO_DataOut},
                mq[0]);

         if (expPop) begin
            popped = mq.pop_front();
            delivered.push_back(popped.data);
            if (bus.IO_MemResponseFlag) mErr = 1'b1;
         end
         if (expPush)
            mq.push_back('{bus.Cmd_CommandEn, bus.Cmd_ResponseRequested, bus.Cmd_DestReg, bus.Cmd_Data});
         if (expPop && bus.IO_RegResponseFlag) begin
            mValid = 1'b1; mDest = bus.IO_DestRegIn; mData = bus.IO_DataIn;
         end else if (mValid && bus.WB_Ready && clk_en) begin
            mValid = 1'b0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic setCmd(input logic v, input logic ce, input logic rr,
                         input logic [3:0] dest, input logic [15:0] data);
      bus.Cmd_Valid             = v;
      bus.Cmd_CommandEn         = ce;
      bus.Cmd_ResponseRequested = rr;
      bus.Cmd_DestReg           = dest;
      bus.Cmd_Data              = data;
   endtask

   task automatic mkCmd(input int i);
      logic [3:0]  d;
      logic [15:0] w;
      d = 4'(i);
      w = 16'(32'h1000 + i);
      setCmd(1'b1, 1'b1, d[0], d, w);
   endtask

   initial begin
      int idx;
      setCmd(1'b1, 1'b1, 1'b0, 4'd0, 16'h1000);
      bus.IO_ACK = 0; bus.IO_RegResponseFlag = 0; bus.IO_MemResponseFlag = 0;
      bus.IO_DestRegIn = '0; bus.IO_DataIn = '0; bus.WB_Ready = 1;

      // 1: reset with Cmd_Valid held high
      step(); step();
      rst_n = 1'b1;
      #1;
      chk("t1_IO_REQ", bus.IO_REQ, 0);
      chk("t1_WB_Valid", bus.WB_Valid, 0);
      chk("t1_Occupancy", occupancy, 0);
      chk("t1_Cmd_Ready", bus.Cmd_Ready, 1);

      // 2: fill, then push+pop at full
      for (int i = 0; i < 4; i++) begin
         mkCmd(i);
         step();
      end
      chk("t2_full_occ", occupancy, 4);
      chk("t2_full_ready", bus.Cmd_Ready, 0);
      chk("t2_head", bus.IO_DataOut, 16'h1000);
      bus.IO_ACK = 1;
      for (int i = 4; i < 10; i++) begin
         mkCmd(i);
         #1;
         chk("t2_steady_occ", occupancy, 4);
         chk("t2_steady_ready", bus.Cmd_Ready, 1);
         step();
      end
      chk("t2_head_after", bus.IO_DataOut, 16'h1006);
      bus.Cmd_Valid = 0;
      for (int i = 0; i < 4; i++) step();
      chk("t2_drained", occupancy, 0);

      // 3: response capture latency
      setCmd(1'b1, 1'b1, 1'b1, 4'd5, 16'h8C00);
      bus.IO_RegResponseFlag = 1; bus.IO_DestRegIn = 4'd5; bus.IO_DataIn = 16'h00A5;
      step();
      bus.Cmd_Valid = 0;
      chk("t3_req_plus1", bus.IO_REQ, 1);
      step();
      chk("t3_wb_valid", bus.WB_Valid, 1);
      chk("t3_wb_dest", bus.WB_DestReg, 5);
      chk("t3_wb_data", bus.WB_Data, 16'h00A5);

      // 4: blocked slot; response-requested head waits, fire-and-forget goes
      bus.WB_Ready = 0; bus.IO_ACK = 0; bus.IO_RegResponseFlag = 0;
      setCmd(1'b1, 1'b1, 1'b1, 4'd7, 16'h8E01);
      step();
      setCmd(1'b1, 1'b0, 1'b0, 4'd2, 16'h4002);
      step();
      bus.Cmd_Valid = 0; bus.IO_ACK = 1;
      bus.IO_RegResponseFlag = 1; bus.IO_DestRegIn = 4'd7; bus.IO_DataIn = 16'h00BB;
      #1;
      chk("t4_A_waits", bus.IO_REQ, 0);
      step();
      chk("t4_A_still", bus.IO_REQ, 0);
      chk("t4_occ2", occupancy, 2);
      bus.WB_Ready = 1;
      #1;
      chk("t4_A_issues", bus.IO_REQ, 1);
      step();
      bus.WB_Ready = 0; bus.IO_RegResponseFlag = 0;
      #1;
      chk("t4_reload_valid", bus.WB_Valid, 1);
      chk("t4_reload_data", bus.WB_Data, 16'h00BB);
      chk("t4_reload_dest", bus.WB_DestReg, 7);
      chk("t4_B_issues", bus.IO_REQ, 1);
      step();
      chk("t4_empty", occupancy, 0);
      chk("t4_slot_held", bus.WB_Valid, 1);
      bus.WB_Ready = 1;
      step();
      chk("t4_drained", bus.WB_Valid, 0);

      // 5: clk_en toggling during a 6-command stream
      delivered.delete();
      idx = 0;
      for (int c = 0; c < 40 && delivered.size() < 6; c++) begin
         clk_en = (c % 2 == 0);
         setCmd(idx < 6, 1'b1, 1'b0, 4'd1, 16'(32'h2000 + idx));
         if (!clk_en) begin
            #1;
            chk("t5_off_req", bus.IO_REQ, 0);
            chk("t5_off_ready", bus.Cmd_Ready, 0);
         end
         step();
         if (clk_en && idx < 6) idx++;
      end
      clk_en = 1; bus.Cmd_Valid = 0;
      chk("t5_count", delivered.size(), 6);
      for (int i = 0; i < 6; i++)
         if (i < delivered.size()) chk("t5_order", delivered[i], 16'(32'h2000 + i));

      // 6: memory response error, then async reset mid-stream
      setCmd(1'b1, 1'b1, 1'b0, 4'd3, 16'h3000);
      bus.IO_MemResponseFlag = 1;
      step();
      bus.Cmd_Valid = 0;
      step();
      bus.IO_MemResponseFlag = 0;
      #1;
      chk("t6_err_set", memRespErr, 1);
      chk("t6_no_wb", bus.WB_Valid, 0);
      bus.IO_ACK = 0;
      for (int i = 0; i < 3; i++) begin
         setCmd(1'b1, 1'b1, (i == 0), 4'(i), 16'(32'h3100 + i));
         step();
      end
      bus.Cmd_Valid = 0; bus.IO_ACK = 1; bus.WB_Ready = 0;
      bus.IO_RegResponseFlag = 1; bus.IO_DestRegIn = 4'd9; bus.IO_DataIn = 16'h00CC;
      step();
      bus.IO_ACK = 0; bus.IO_RegResponseFlag = 0;
      #1;
      chk("t6_err_sticky", memRespErr, 1);
      chk("t6_wb_full", bus.WB_Valid, 1);
      chk("t6_occ2", occupancy, 2);
      rst_n = 1'b0;
      #1;
      chk("t6_arst_occ", occupancy, 0);
      chk("t6_arst_req", bus.IO_REQ, 0);
      chk("t6_arst_wb", bus.WB_Valid, 0);
      chk("t6_arst_wbdata", bus.WB_Data, 0);
      chk("t6_arst_err", memRespErr, 0);
      chk("t6_arst_ready", bus.Cmd_Ready, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1; bus.WB_Ready = 1;
      step(); step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
